// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory controller.
package mem_access_ctrl_pkg;

    localparam int unsigned WORD_W_DEFAULT = 32;
    localparam int unsigned CNT_W_DEFAULT  = 16;

    // DONE parks a completed access until the pipeline advances.
    typedef enum logic {
        IDLE = 1'b0,
        DONE = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_access_ctrl_llsc_link.sv
// LL/SC link register: set by a completed ll, cleared by local stores to the linked
// address, a successful sc, or a coherence invalidate of the linked address.
module mem_access_ctrl_llsc_link #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ll_done,
    input  logic [WORD_W-1:0] ll_addr,
    input  logic              st_done,
    input  logic              sc_done,
    input  logic [WORD_W-1:0] st_addr,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              link_valid,
    output logic [WORD_W-1:0] link_addr
);

    logic              valid_q;
    logic [WORD_W-1:0] addr_q;
    logic              snoop_new;
    logic              snoop_old;
    logic              local_clr;

    assign snoop_new = ccinv & (ccsnoopaddr == ll_addr);
    assign snoop_old = ccinv & (ccsnoopaddr == addr_q);
    assign local_clr = sc_done | (st_done & (st_addr == addr_q));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else if (ll_done) begin
            // An invalidate of the line being linked this very cycle wins.
            valid_q <= ~snoop_new;
            addr_q  <= ll_addr;
        end else if (local_clr | snoop_old) begin
            valid_q <= 1'b0;
        end
    end

    assign link_valid = valid_q;
    assign link_addr  = addr_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage dcache request controller: issues reads/writes, stalls until dhit, holds
// results while the stage is blocked, and owns the LL/SC link.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEFAULT,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              op_valid,
    input  logic              memren,
    input  logic              memwen,
    input  logic              is_ll,
    input  logic              is_sc,
    input  logic              halt,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] store_data,
    input  logic              advance,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] load_data,
    output logic              sc_result,
    output logic              mem_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    mem_state_t        state_q, state_d;
    logic [WORD_W-1:0] load_q;
    logic              sc_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic              link_valid;
    logic [WORD_W-1:0] link_addr;
    logic              sc_fail;
    logic              need;
    logic              complete;
    logic              capture;

    assign sc_fail  = is_sc & ~(link_valid & (link_addr == addr));
    assign need     = op_valid & ~halt & (memren | (memwen & ~sc_fail));
    assign complete = (state_q == IDLE) & need & dhit & ~RST;

    always_comb begin
        state_d   = state_q;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        mem_busy  = 1'b0;
        load_data = load_q;
        sc_result = sc_q;
        capture   = 1'b0;
        unique case (state_q)
            IDLE: begin
                dmemREN   = need & memren;
                dmemWEN   = need & memwen;
                mem_busy  = need & ~dhit;
                sc_result = is_sc & ~sc_fail;
                if (need & dhit & memren) begin
                    load_data = dmemload;
                end
                if (need & dhit & ~advance) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (advance) begin
                    state_d = IDLE;
                end
            end
        endcase
        // Reset drops every request and result at once, not at the next edge.
        if (RST) begin
            dmemREN   = 1'b0;
            dmemWEN   = 1'b0;
            mem_busy  = 1'b0;
            sc_result = 1'b0;
            load_data = '0;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            load_q  <= '0;
            sc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // sc_q is held because the link clears on the very edge the sc completes.
            if (capture) begin
                sc_q <= is_sc & ~sc_fail;
                if (memren) begin
                    load_q <= dmemload;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else if (mem_busy && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign dmemaddr  = addr;
    assign dmemstore = store_data;

    mem_access_ctrl_llsc_link #(
        .WORD_W (WORD_W)
    ) u_link (
        .CLK         (CLK),
        .RST         (RST),
        .ll_done     (complete & memren & is_ll),
        .ll_addr     (addr),
        .st_done     (complete & memwen),
        .sc_done     (complete & memwen & is_sc),
        .st_addr     (addr),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .link_valid  (link_valid),
        .link_addr   (link_addr)
    );

endmodule
